// File: rtl/m_if_pkg.sv
// Shared types and constants for the three-requester arbiter.
package m_if_pkg;

  localparam int unsigned N_REQ = 3;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // sel value reported while nobody owns the datapath
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  // Grant index to one-hot grant vector
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/m_if_arb_pick.sv
// Combinational winner pick over a candidate request vector.
module m_if_arb_pick
  import m_if_pkg::*;
(
  input  logic [N_REQ-1:0] cand_i,
  input  logic             mode_i,
  input  logic [1:0]       last_i,
  output logic [1:0]       winner_o,
  output logic             found_o
);

  // Fixed: lowest index wins. Round robin: scan last+1, last+2, last+3 (mod 3).
  always_comb begin
    winner_o = 2'd0;
    found_o  = |cand_i;
    if (mode_i == MODE_FIXED) begin
      if (cand_i[0])      winner_o = 2'd0;
      else if (cand_i[1]) winner_o = 2'd1;
      else if (cand_i[2]) winner_o = 2'd2;
    end else begin
      case (last_i)
        2'd0: begin
          if (cand_i[1])      winner_o = 2'd1;
          else if (cand_i[2]) winner_o = 2'd2;
          else if (cand_i[0]) winner_o = 2'd0;
        end
        2'd1: begin
          if (cand_i[2])      winner_o = 2'd2;
          else if (cand_i[0]) winner_o = 2'd0;
          else if (cand_i[1]) winner_o = 2'd1;
        end
        default: begin
          if (cand_i[0])      winner_o = 2'd0;
          else if (cand_i[1]) winner_o = 2'd1;
          else if (cand_i[2]) winner_o = 2'd2;
        end
      endcase
    end
  end

endmodule

// File: rtl/m_if_arb.sv
// Three-requester arbiter with bounded ownership and a registered shared datapath.
module m_if_arb
  import m_if_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [2:0]        req_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] din_one_i,
  input  logic [DATA_W-1:0] din_two_i,
  input  logic [DATA_W-1:0] din_three_i,
  output logic [2:0]        gnt_o,
  output logic [1:0]        sel_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_vld_o
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [1:0]        last_q, last_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  logic [2:0] cand;
  logic [1:0] win;
  logic       found;
  logic       own_req;
  logic       keep;

  // Owner still requesting; gnt_q is zero in idle so this is then 0
  assign own_req = |(req_i & gnt_q);
  assign keep    = (state_q == StGrant) && own_req && (hold_q < HoldLast);
  // On release the current owner is masked so others get a turn first
  assign cand    = (state_q == StIdle) ? req_i : (req_i & ~gnt_q);

  m_if_arb_pick u_pick (
    .cand_i   (cand),
    .mode_i   (mode_i),
    .last_i   (last_q),
    .winner_o (win),
    .found_o  (found)
  );

  // Next-state: hold, re-arbitrate without bubble, regrant sole requester, or go idle
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = idx2onehot(win);
          sel_d   = win;
          hold_d  = '0;
          last_d  = win;
        end
      end
      StGrant: begin
        if (keep) begin
          hold_d = hold_q + 4'd1;
        end else if (found) begin
          gnt_d  = idx2onehot(win);
          sel_d  = win;
          hold_d = '0;
          last_d = win;
        end else if (own_req) begin
          hold_d = '0;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
          sel_d   = SEL_NONE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        sel_d   = SEL_NONE;
        hold_d  = '0;
      end
    endcase
  end

  // Datapath: capture the source granted before this edge, so dout lags gnt by one
  always_comb begin
    dout_d = dout_q;
    vld_d  = 1'b0;
    if (gnt_q[0]) begin
      dout_d = din_one_i;
      vld_d  = 1'b1;
    end else if (gnt_q[1]) begin
      dout_d = din_two_i;
      vld_d  = 1'b1;
    end else if (gnt_q[2]) begin
      dout_d = din_three_i;
      vld_d  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      hold_q  <= '0;
      last_q  <= 2'd2;
      gnt_q   <= '0;
      sel_q   <= SEL_NONE;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;

endmodule

// File: tb/tb_m_if_arb.sv
// Directed bench: vector table on a MAX_HOLD=4 instance, round-robin sequence on MAX_HOLD=1.
module tb_m_if_arb;

  localparam logic [7:0] D1 = 8'h11;
  localparam logic [7:0] D2 = 8'hA5;
  localparam logic [7:0] D3 = 8'h33;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic       mode;
  logic [7:0] din_one, din_two, din_three;

  logic [2:0] gnt4, gnt1;
  logic [1:0] sel4, sel1;
  logic [7:0] dout4, dout1;
  logic       vld4, vld1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  m_if_arb #(.DATA_W(8), .MAX_HOLD(4)) dut4 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .mode_i      (mode),
    .din_one_i   (din_one),
    .din_two_i   (din_two),
    .din_three_i (din_three),
    .gnt_o       (gnt4),
    .sel_o       (sel4),
    .dout_o      (dout4),
    .dout_vld_o  (vld4)
  );

  m_if_arb #(.DATA_W(8), .MAX_HOLD(1)) dut1 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .mode_i      (mode),
    .din_one_i   (din_one),
    .din_two_i   (din_two),
    .din_three_i (din_three),
    .gnt_o       (gnt1),
    .sel_o       (sel1),
    .dout_o      (dout1),
    .dout_vld_o  (vld1)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic       mode;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic m,
                              input logic [2:0] g, input logic [1:0] s,
                              input logic [7:0] d, input logic v);
    vec_t t;
    t.rst_n = r; t.req = q; t.mode = m; t.gnt = g; t.sel = s; t.dout = d; t.vld = v;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [2:0] g, input logic [1:0] s,
                     input logic [7:0] d, input logic v, input logic [2:0] eg,
                     input logic [1:0] es, input logic [7:0] ed, input logic ev);
    checks++;
    if ({g, s, d, v} !== {eg, es, ed, ev}) begin
      errors++;
      $display("FAIL %s: gnt/sel/dout/vld got %b/%0d/%h/%b want %b/%0d/%h/%b",
               name, g, s, d, v, eg, es, ed, ev);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b111; mode = 1'b0;
    din_one = D1; din_two = D2; din_three = D3;

    // Reset held with all requesting, then idle
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 2'd3, 8'h00, 0));
    vecs.push_back(mk(0, 3'b111, 0, 3'b000, 2'd3, 8'h00, 0));
    vecs.push_back(mk(1, 3'b000, 0, 3'b000, 2'd3, 8'h00, 0));
    vecs.push_back(mk(1, 3'b000, 0, 3'b000, 2'd3, 8'h00, 0));
    // Fixed priority: source 1 for 4 cycles, then 2 for 4, then back to 1
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, 8'h00, 0));
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, D2, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, D2, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, D2, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b100, 2'd2, D2, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, D3, 1));
    vecs.push_back(mk(1, 3'b110, 0, 3'b010, 2'd1, D2, 1));
    // Early release: owner 1 drops, 0 wins; 0 drops after 2 cycles, 2 follows directly
    vecs.push_back(mk(1, 3'b101, 0, 3'b001, 2'd0, D2, 1));
    vecs.push_back(mk(1, 3'b101, 0, 3'b001, 2'd0, D1, 1));
    vecs.push_back(mk(1, 3'b100, 0, 3'b100, 2'd2, D1, 1));
    // Hold count restarted: source 2 keeps 4 full cycles before 0 gets in
    vecs.push_back(mk(1, 3'b101, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b101, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b101, 0, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b101, 0, 3'b001, 2'd0, D3, 1));
    // All drop: idle, dout holds last value with vld low
    vecs.push_back(mk(1, 3'b000, 0, 3'b000, 2'd3, D1, 1));
    vecs.push_back(mk(1, 3'b000, 0, 3'b000, 2'd3, D1, 0));
    // Sole requester for 10 cycles: continuous regrant, vld never drops
    vecs.push_back(mk(1, 3'b001, 0, 3'b001, 2'd0, D1, 0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(1, 3'b001, 0, 3'b001, 2'd0, D1, 1));
    // Grant to source 2 under mode 0, switch to mode 1 mid-grant, reset mid-grant
    vecs.push_back(mk(1, 3'b100, 0, 3'b100, 2'd2, D1, 1));
    vecs.push_back(mk(1, 3'b111, 1, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(1, 3'b111, 1, 3'b100, 2'd2, D3, 1));
    vecs.push_back(mk(0, 3'b111, 1, 3'b000, 2'd3, 8'h00, 0));
    // After reset round robin starts at source 0, then rotates to 1
    vecs.push_back(mk(1, 3'b111, 1, 3'b001, 2'd0, 8'h00, 0));
    vecs.push_back(mk(1, 3'b111, 1, 3'b001, 2'd0, D1, 1));
    vecs.push_back(mk(1, 3'b111, 1, 3'b001, 2'd0, D1, 1));
    vecs.push_back(mk(1, 3'b111, 1, 3'b001, 2'd0, D1, 1));
    vecs.push_back(mk(1, 3'b111, 1, 3'b010, 2'd1, D1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      mode  = vecs[i].mode;
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d", i), gnt4, sel4, dout4, vld4,
          vecs[i].gnt, vecs[i].sel, vecs[i].dout, vecs[i].vld);
    end

    // MAX_HOLD=1 round robin: rotate every cycle, dout one cycle behind
    begin
      logic [2:0] exp_g[6];
      logic [1:0] exp_s[6];
      logic [7:0] exp_d[6];
      logic       exp_v[6];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_s = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      exp_d = '{8'h00, D1, D2, D3, D1, D2};
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      rst_n = 1'b0; req = 3'b111; mode = 1'b1;
      @(posedge clk);
      #1;
      cmp("rr1_reset", gnt1, sel1, dout1, vld1, 3'b000, 2'd3, 8'h00, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        cmp($sformatf("rr1_%0d", i), gnt1, sel1, dout1, vld1,
            exp_g[i], exp_s[i], exp_d[i], exp_v[i]);
      end
    end

    // Source drops at the edge it would be granted: not granted
    rst_n = 1'b0; req = 3'b000; mode = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    @(posedge clk);
    #1;
    cmp("drop_at_edge", gnt4, sel4, dout4, vld4, 3'b000, 2'd3, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
